// File: rtl/reg_array_bypass_if.sv
// rtl/reg_array_bypass_if.sv - write/read port bundle for the bypassing register array
interface reg_array_bypass_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);

  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic [WIDTH/8-1:0] wr_be;
  logic [AW-1:0]      rd_addr_a;
  logic [WIDTH-1:0]   rd_data_a;
  logic [AW-1:0]      rd_addr_b;
  logic [WIDTH-1:0]   rd_data_b;
  logic               clr_all;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_addr_a, rd_addr_b, clr_all,
    input  rd_data_a, rd_data_b
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_addr_a, rd_addr_b, clr_all,
    output rd_data_a, rd_data_b
  );
endinterface

// File: rtl/reg_array_bypass.sv
// rtl/reg_array_bypass.sv - 2R1W register file with byte masks, optional zero register and write bypass
module reg_array_bypass #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic               clk,
  input logic               rst,
  reg_array_bypass_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] wr_merged;
  logic             wr_fire;
  logic             wr_to_zero;

  // A write lands only when nothing of higher priority is active this cycle.
  assign wr_to_zero = (ZERO_REG != 0) && (bus.wr_addr == '0);
  assign wr_fire    = bus.wr_en && !rst && !bus.clr_all && !wr_to_zero;

  always_comb begin
    wr_merged = mem_q[bus.wr_addr];
    for (int i = 0; i < NB; i++) begin
      if (bus.wr_be[i]) begin
        wr_merged[8*i +: 8] = bus.wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    for (int w = 0; w < DEPTH; w++) begin
      mem_d[w] = mem_q[w];
    end
    if (bus.clr_all) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_d[w] = '0;
      end
    end else if (wr_fire) begin
      mem_d[bus.wr_addr] = wr_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= mem_d[w];
      end
    end
  end

  // Register 0 masks everything, then same-cycle bypass, then stored contents.
  always_comb begin
    if ((ZERO_REG != 0) && (bus.rd_addr_a == '0)) begin
      bus.rd_data_a = '0;
    end else if ((BYPASS != 0) && wr_fire && (bus.rd_addr_a == bus.wr_addr)) begin
      bus.rd_data_a = wr_merged;
    end else begin
      bus.rd_data_a = mem_q[bus.rd_addr_a];
    end
  end

  always_comb begin
    if ((ZERO_REG != 0) && (bus.rd_addr_b == '0)) begin
      bus.rd_data_b = '0;
    end else if ((BYPASS != 0) && wr_fire && (bus.rd_addr_b == bus.wr_addr)) begin
      bus.rd_data_b = wr_merged;
    end else begin
      bus.rd_data_b = mem_q[bus.rd_addr_b];
    end
  end
endmodule

// File: tb/tb_reg_array_bypass.sv
// tb/tb_reg_array_bypass.sv - scoreboard bench: two configurations driven in lockstep against a reference model
module tb_reg_array_bypass;
  localparam int W = 64;
  localparam int D = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [63:0]  wr_data;
  logic [7:0]   wr_be;
  logic [4:0]   rd_addr_a;
  logic [4:0]   rd_addr_b;
  logic         clr_all;

  reg_array_bypass_if #(.WIDTH(W), .DEPTH(D)) if0 ();
  reg_array_bypass_if #(.WIDTH(W), .DEPTH(D)) if1 ();

  assign if0.wr_en = wr_en;     assign if1.wr_en = wr_en;
  assign if0.wr_addr = wr_addr; assign if1.wr_addr = wr_addr;
  assign if0.wr_data = wr_data; assign if1.wr_data = wr_data;
  assign if0.wr_be = wr_be;     assign if1.wr_be = wr_be;
  assign if0.rd_addr_a = rd_addr_a; assign if1.rd_addr_a = rd_addr_a;
  assign if0.rd_addr_b = rd_addr_b; assign if1.rd_addr_b = rd_addr_b;
  assign if0.clr_all = clr_all; assign if1.clr_all = clr_all;

  reg_array_bypass #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );
  reg_array_bypass #(.WIDTH(W), .DEPTH(D), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  // m0 models ZERO_REG=1/BYPASS=1, m1 models ZERO_REG=0/BYPASS=0.
  logic [63:0] m0 [D];
  logic [63:0] m1 [D];
  logic [63:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] model_rd(input int cfg, input logic [4:0] a);
    if (cfg == 0) begin
      if (a == 5'd0) return 64'd0;
      if (wr_en && !rst && !clr_all && a == wr_addr)
        return merge(m0[a], wr_data, wr_be);
      return m0[a];
    end
    return m1[a];
  endfunction

  task automatic step(input string tag, input logic r, input logic clr, input logic we,
                      input logic [4:0] wa, input logic [63:0] wd, input logic [7:0] be,
                      input logic [4:0] ra, input logic [4:0] rb, input bit chk);
    rst = r; clr_all = clr; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_addr_a = ra; rd_addr_b = rb;
    if (chk) begin
      exp_q.push_back(model_rd(0, ra));
      exp_q.push_back(model_rd(0, rb));
      exp_q.push_back(model_rd(1, ra));
      exp_q.push_back(model_rd(1, rb));
    end
    @(negedge clk);
    if (chk) begin
      check_val({tag, "/z1b1_a"}, if0.rd_data_a, exp_q.pop_front());
      check_val({tag, "/z1b1_b"}, if0.rd_data_b, exp_q.pop_front());
      check_val({tag, "/z0b0_a"}, if1.rd_data_a, exp_q.pop_front());
      check_val({tag, "/z0b0_b"}, if1.rd_data_b, exp_q.pop_front());
    end
    @(posedge clk);
    if (r || clr) begin
      for (int i = 0; i < D; i++) begin m0[i] = '0; m1[i] = '0; end
    end else if (we) begin
      if (wa != 5'd0) m0[wa] = merge(m0[wa], wd, be);
      m1[wa] = merge(m1[wa], wd, be);
    end
    #1;
  endtask

  initial begin
    logic [63:0] ones, fives, aaaa, v;
    logic [4:0]  a, b, wa;
    ones  = 64'h1111_1111_1111_1111;
    fives = 64'h5555_5555_5555_5555;
    aaaa  = 64'hAAAA_AAAA_AAAA_AAAA;

    step("init_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("post_rst", 0, 0, 0, 0, 0, 0, 5'd4, 5'd31, 1);

    for (int i = 0; i < D; i++) step("fill1", 0, 0, 1, 5'(i), ones, 8'hFF, 5'(i), 5'(i+1), 1);
    step("rst_prio", 1, 1, 1, 5'd9, 64'hFFFF_0000_FFFF_0000, 8'hFF, 5'd9, 5'd9, 1);
    for (int i = 0; i < D; i++) step("rst_rd", 0, 0, 0, 0, 0, 0, 5'(i), 5'(D-1-i), 1);

    step("full_wr", 0, 0, 1, 5'd5, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 5'd5, 5'd6, 1);
    step("full_rd", 0, 0, 0, 0, 0, 0, 5'd5, 5'd6, 1);
    step("mask_wr", 0, 0, 1, 5'd5, 64'h0123_4567_89AB_CDEF, 8'h0F, 5'd5, 5'd5, 1);
    step("mask_rd", 0, 0, 0, 0, 0, 0, 5'd5, 5'd5, 1);
    step("be_zero", 0, 0, 1, 5'd5, 64'h0, 8'h00, 5'd5, 5'd5, 1);
    step("we_zero", 0, 0, 0, 5'd5, 64'h0, 8'hFF, 5'd5, 5'd5, 1);

    step("zero_wr", 0, 0, 1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 5'd0, 5'd0, 1);
    step("zero_rd", 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 1);

    step("by_set3", 0, 0, 1, 5'd3, 64'h3333_4444_5555_6666, 8'hFF, 5'd3, 5'd7, 1);
    step("by_set7", 0, 0, 1, 5'd7, aaaa, 8'hFF, 5'd7, 5'd3, 1);
    step("bypass",  0, 0, 1, 5'd7, fives, 8'h01, 5'd7, 5'd3, 1);
    step("by_rd",   0, 0, 0, 0, 0, 0, 5'd7, 5'd7, 1);
    step("by_both", 0, 0, 1, 5'd3, fives, 8'hF0, 5'd3, 5'd3, 1);

    for (int i = 1; i < D; i++) step("fill2", 0, 0, 1, 5'(i), {$urandom, $urandom}, 8'hFF, 5'(i), 5'(i-1), 1);
    step("clr_wr", 0, 1, 1, 5'd12, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF, 5'd12, 5'd13, 1);
    for (int i = 0; i < D; i++) step("clr_rd", 0, 0, 0, 0, 0, 0, 5'(i), 5'(i), 1);

    for (int n = 0; n < 400; n++) begin
      wa = 5'($urandom_range(0, D-1));
      a  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, D-1));
      b  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, D-1));
      v  = {$urandom, $urandom};
      step("rand", ($urandom_range(0, 79) == 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 9) < 7), wa, v, 8'($urandom), a, b, 1);
    end

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
